// File: rtl/capture_packer_if.sv
// capture_packer_if
//   Bundles the capture request, sample stream and frame output of
//   capture_packer.
//   slave  : seen by capture_packer (inputs start/numFrames/inValid/dataIn;
//            outputs dataOut/outValid/busy/done/closed)
//   master : seen by whatever drives the capture (directions reversed)
interface capture_packer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_NUM   = 8,
  parameter int CNT_WIDTH = 16
);
  logic                        start;
  logic [CNT_WIDTH-1:0]        numFrames;
  logic                        inValid;
  logic signed [IN_WIDTH-1:0]  dataIn;
  logic signed [IN_WIDTH-1:0]  dataOut [OUT_NUM];
  logic                        outValid;
  logic                        busy;
  logic                        done;
  logic                        closed;

  modport slave (
    input  start, numFrames, inValid, dataIn,
    output dataOut, outValid, busy, done, closed
  );

  modport master (
    output start, numFrames, inValid, dataIn,
    input  dataOut, outValid, busy, done, closed
  );
endinterface

// File: rtl/capture_packer.sv
// capture_packer
//   Collects a stream of signed samples into frames of OUT_NUM samples and
//   presents each completed frame on dataOut with a one-cycle outValid pulse.
//   A capture is armed by start with a nonzero numFrames; after that many
//   frames the block parks in DONE (terminal until rst) and raises closed one
//   cycle later as an end-of-capture signal for a file sink.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - capture_packer_if.slave (start, numFrames, inValid, dataIn,
//            dataOut[OUT_NUM], outValid, busy, done, closed)
module capture_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_NUM   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  capture_packer_if.slave   bus
);

  // OUT_NUM=1 still needs a 1-bit index to keep the vectors legal.
  localparam int IDX_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(OUT_NUM - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] target_reg;
  logic [CNT_WIDTH-1:0] frame_cnt_reg;
  logic [CNT_WIDTH-1:0] frame_cnt_inc;
  logic [IDX_W-1:0]     idx_reg;
  logic                 out_valid_reg;
  logic                 closed_reg;

  logic load;       // arm a new capture this edge
  logic accept;     // write dataIn into slot idx_reg this edge
  logic frame_end;  // the accepted sample completes the frame

  assign frame_cnt_inc = frame_cnt_reg + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    accept     = 1'b0;
    frame_end  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && (bus.numFrames != '0)) begin
          load       = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.inValid) begin
          accept = 1'b1;
          if (idx_reg == LAST_SLOT) begin
            frame_end = 1'b1;
            // The counter only ever reaches target_reg, so a target of
            // all-ones finishes without wrapping.
            if (frame_cnt_inc == target_reg) state_next = DONE;
          end
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_reg    <= '0;
      frame_cnt_reg <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      closed_reg    <= 1'b0;
    end else begin
      out_valid_reg <= frame_end;
      // Sticky: once DONE has been seen for a cycle, closed stays up.
      closed_reg    <= closed_reg | (state_reg == DONE);
      if (load) begin
        target_reg    <= bus.numFrames;
        frame_cnt_reg <= '0;
        idx_reg       <= '0;
      end else if (accept) begin
        if (frame_end) begin
          idx_reg       <= '0;
          frame_cnt_reg <= frame_cnt_inc;
        end else begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  // Per-slot collect register and output word. On the frame-completing edge
  // the last slot's output takes dataIn directly, so the published frame
  // includes the sample accepted on that same edge.
  for (genvar gi = 0; gi < OUT_NUM; gi++) begin : g_slot
    logic                       hit;
    logic signed [IN_WIDTH-1:0] slot_reg;
    logic signed [IN_WIDTH-1:0] word_reg;

    assign hit = accept && (idx_reg == IDX_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_reg <= '0;
        word_reg <= '0;
      end else begin
        if (hit)       slot_reg <= bus.dataIn;
        if (frame_end) word_reg <= hit ? bus.dataIn : slot_reg;
      end
    end

    assign bus.dataOut[gi] = word_reg;
  end

  assign bus.outValid = out_valid_reg;
  assign bus.busy     = (state_reg == CAPTURE);
  assign bus.done     = (state_reg == DONE);
  assign bus.closed   = closed_reg;

endmodule

// File: tb/tb_capture_packer.sv
// tb_capture_packer
//   Directed bench for capture_packer with OUT_NUM=4. A queue-based frame
//   model predicts every output each cycle; literal frame lists pin the model.
module tb_capture_packer;

  localparam int IW = 8;
  localparam int ON = 4;
  localparam int CW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  capture_packer_if #(.IN_WIDTH(IW), .OUT_NUM(ON), .CNT_WIDTH(CW)) ifc ();

  capture_packer #(.IN_WIDTH(IW), .OUT_NUM(ON), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 capturing, 2 finished
  int m_mode;
  int m_left;
  int coll[$];
  int exp_out[ON];
  bit exp_valid;
  bit exp_closed;
  int frame_log[$];   // packed frames seen on DUT outValid
  int vec[$];
  int exp_frames[$];

  function automatic int sext8(input int d);
    logic signed [7:0] t;
    t = d[7:0];
    return int'(t);
  endfunction

  function automatic int pack4(input int a, input int b, input int c, input int d);
    return {a[7:0], b[7:0], c[7:0], d[7:0]};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_left = 0;
    coll.delete();
    for (int i = 0; i < ON; i++) exp_out[i] = 0;
    exp_valid  = 1'b0;
    exp_closed = 1'b0;
  endtask

  task automatic model_update(input bit s, input int nf, input bit v, input int d);
    exp_closed = exp_closed || (m_mode == 2);
    exp_valid  = 1'b0;
    case (m_mode)
      0: if (s && nf != 0) begin
        m_mode = 1;
        m_left = nf;
        coll.delete();
      end
      1: if (v) begin
        coll.push_back(sext8(d));
        if (coll.size() == ON) begin
          for (int i = 0; i < ON; i++) exp_out[i] = coll[i];
          coll.delete();
          exp_valid = 1'b1;
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic compare_all();
    chk("outValid", int'(ifc.outValid), int'(exp_valid));
    chk("busy",     int'(ifc.busy),     int'(m_mode == 1));
    chk("done",     int'(ifc.done),     int'(m_mode == 2));
    chk("closed",   int'(ifc.closed),   int'(exp_closed));
    for (int i = 0; i < ON; i++)
      chk($sformatf("dataOut[%0d]", i), int'(ifc.dataOut[i]), exp_out[i]);
    if (ifc.outValid === 1'b1)
      frame_log.push_back(pack4(int'(ifc.dataOut[0]), int'(ifc.dataOut[1]),
                                int'(ifc.dataOut[2]), int'(ifc.dataOut[3])));
  endtask

  // One clock cycle: drive, clock, advance model, compare.
  task automatic step(input bit s, input int nf, input bit v, input int d);
    ifc.start     = s;
    ifc.numFrames = CW'(nf);
    ifc.inValid   = v;
    ifc.dataIn    = IW'(d);
    @(posedge clk);
    model_update(s, nf, v, d);
    #1;
    compare_all();
    $display("t=%0t start=%0b nf=%0d inValid=%0b dataIn=%0d -> outValid=%0b busy=%0b done=%0b closed=%0b",
             $time, s, nf, v, sext8(d), ifc.outValid, ifc.busy, ifc.done, ifc.closed);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic feed(input int q[$]);
    foreach (q[i]) step(1'b0, 0, 1'b1, q[i]);
  endtask

  task automatic chk_frames(input string name, input int q[$]);
    chk({name, ".count"}, frame_log.size(), q.size());
    foreach (q[i])
      chk($sformatf("%s.frame%0d", name, i),
          (i < frame_log.size()) ? frame_log[i] : 0, q[i]);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, ".outValid"}, int'(ifc.outValid), 0);
    chk({name, ".busy"},     int'(ifc.busy),     0);
    chk({name, ".done"},     int'(ifc.done),     0);
    chk({name, ".closed"},   int'(ifc.closed),   0);
    for (int i = 0; i < ON; i++)
      chk($sformatf("%s.dataOut[%0d]", name, i), int'(ifc.dataOut[i]), 0);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic pulse_reset(input string name);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs(name);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("t=%0t reset pulse %s", $time, name);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.numFrames = '0;
    ifc.inValid = 1'b0;
    ifc.dataIn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Two frames back to back, then terminal DONE.
    frame_log.delete();
    step(1'b1, 2, 1'b0, 0);
    vec = '{1, -2, 3, -4, 5, 6, 7, 8};
    feed(vec);
    chk("two_frames.done_at_last", int'(ifc.done), 1);
    chk("two_frames.closed_lag",   int'(ifc.closed), 0);
    idle(1);
    chk("two_frames.closed", int'(ifc.closed), 1);
    exp_frames = '{pack4(1, -2, 3, -4), pack4(5, 6, 7, 8)};
    chk_frames("two_frames", exp_frames);

    // DONE ignores start and samples.
    frame_log.delete();
    step(1'b1, 3, 1'b1, 99);
    for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b1, i + 40);
    chk("done_hold.done",    int'(ifc.done), 1);
    chk("done_hold.closed",  int'(ifc.closed), 1);
    chk("done_hold.dataOut3", int'(ifc.dataOut[3]), 8);
    exp_frames = '{};
    chk_frames("done_hold", exp_frames);

    // numFrames=0 is ignored.
    pulse_reset("rst1");
    frame_log.delete();
    step(1'b1, 0, 1'b0, 0);
    vec = '{9, 9, 9, 9, 9};
    feed(vec);
    chk("zero_frames.busy", int'(ifc.busy), 0);
    chk_frames("zero_frames", exp_frames);

    // Gap in the middle of a frame.
    step(1'b1, 1, 1'b0, 0);
    vec = '{10, 11};
    feed(vec);
    idle(5);
    chk("gap.busy", int'(ifc.busy), 1);
    vec = '{12, 13};
    feed(vec);
    idle(2);
    exp_frames = '{pack4(10, 11, 12, 13)};
    chk_frames("gap", exp_frames);

    // Extreme sample values.
    pulse_reset("rst2");
    frame_log.delete();
    step(1'b1, 1, 1'b0, 0);
    vec = '{-128, 127, 0, -1};
    feed(vec);
    chk("extremes.d0", int'(ifc.dataOut[0]), -128);
    chk("extremes.d1", int'(ifc.dataOut[1]), 127);
    exp_frames = '{pack4(-128, 127, 0, -1)};
    chk_frames("extremes", exp_frames);

    // Reset in the middle of frame 2 of 3.
    pulse_reset("rst3");
    frame_log.delete();
    step(1'b1, 3, 1'b0, 0);
    vec = '{1, 2, 3, 4, 5, 6};
    feed(vec);
    pulse_reset("mid_capture");
    vec = '{7, 8, 9, 10, 11};
    feed(vec);
    chk("mid_capture.idle", int'(ifc.busy), 0);
    step(1'b1, 1, 1'b0, 0);
    vec = '{21, 22, 23, 24};
    feed(vec);
    idle(1);
    exp_frames = '{pack4(1, 2, 3, 4), pack4(21, 22, 23, 24)};
    chk_frames("mid_capture", exp_frames);

    // start during CAPTURE is ignored.
    pulse_reset("rst4");
    frame_log.delete();
    step(1'b1, 1, 1'b0, 0);
    vec = '{1, 2};
    feed(vec);
    step(1'b1, 5, 1'b1, 3);
    vec = '{4};
    feed(vec);
    chk("restart_ignored.done", int'(ifc.done), 1);
    exp_frames = '{pack4(1, 2, 3, 4)};
    chk_frames("restart_ignored", exp_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_packer.md
CAPTURE_PACKER -- requirements
Module: capture_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8: bit width of one signed sample.
REQ-002 Parameter OUT_NUM, default 8: samples per output vector (frame); legal range 1..256.
REQ-003 Parameter CNT_WIDTH, default 16: width of the frame-count request and counter.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port start  input  1  capture request; sampled only in IDLE.
REQ-007 Port numFrames  input  CNT_WIDTH  number of frames to capture; sampled with start.
REQ-008 Port inValid  input  1  dataIn holds a valid sample this cycle.
REQ-009 Port dataIn  input  signed IN_WIDTH  incoming sample.
REQ-010 Port dataOut  output  signed IN_WIDTH x OUT_NUM (unpacked array)  last completed frame; element 0 is the oldest sample.
REQ-011 Port outValid  output  1  one-cycle pulse marking a new frame on dataOut; drives the file sink enable.
REQ-012 Port busy  output  1  high while in CAPTURE.
REQ-013 Port done  output  1  high while in DONE.
REQ-014 Port closed  output  1  end-of-capture close request for the file sink; rises one cycle after done.

Function
REQ-015 Block SHALL implement states IDLE, CAPTURE and DONE.
REQ-016 IDLE: start=1 with numFrames!=0 SHALL latch numFrames, clear slot index and frame counter, and enter CAPTURE next cycle.
REQ-017 IDLE: start=1 with numFrames=0 SHALL be ignored; state stays IDLE.
REQ-018 IDLE and DONE: inValid SHALL be ignored; no slot writes.
REQ-019 CAPTURE: each cycle with inValid=1 SHALL write dataIn to collect-buffer slot index and increment index; cycles with inValid=0 SHALL hold all state.
REQ-020 When a sample is written to slot OUT_NUM-1, the next edge SHALL copy the full collect buffer, including that sample, to dataOut, assert outValid for exactly one cycle, reset index to 0 and increment the frame counter.
REQ-021 Latency: outValid SHALL be high in the cycle immediately after the edge that accepts the last sample of a frame.
REQ-022 dataOut SHALL be held stable from one outValid to the next; collection of the following frame SHALL NOT disturb it.
REQ-023 Back-to-back: inValid=1 in the outValid cycle SHALL be accepted into slot 0 of the next frame; no sample is lost.
REQ-024 When the frame counter reaches the latched numFrames, the edge producing the final outValid SHALL also move the state to DONE; extra samples are ignored.
REQ-025 DONE SHALL be terminal: done=1; closed=1 from the following cycle onward; start ignored; exit only by rst.
REQ-026 start in CAPTURE SHALL be ignored; the capture in progress is unaffected.
REQ-027 Frame counter SHALL be CNT_WIDTH bits; numFrames = 2^CNT_WIDTH-1 SHALL complete without wrap.
REQ-028 OUT_NUM=1: every accepted sample SHALL produce one outValid with dataOut[0] = that sample.
REQ-029 busy SHALL equal (state==CAPTURE); done SHALL equal (state==DONE).

Reset
REQ-030 rst=1 SHALL immediately, without a clock, force state IDLE, and set outValid, busy, done and closed to 0, index and frame counter to 0, and dataOut and collect buffer to all zeros.
REQ-031 rst asserted mid-frame or mid-capture SHALL discard the partial frame; no outValid SHALL be produced for it after release.
REQ-032 After rst deasserts, the block SHALL require a new start to capture.

Verification
REQ-033 OUT_NUM=4, numFrames=2, start, then samples 1,-2,3,-4,5,6,7,8 every cycle -> outValid one cycle after -4 with dataOut={1,-2,3,-4}; after 8 with {5,6,7,8}; done next cycle; closed the cycle after that.
REQ-034 OUT_NUM=4, numFrames=1, samples 10,11 then inValid low 5 cycles, then 12,13 -> single outValid after 13, dataOut={10,11,12,13}, busy high throughout the gap.
REQ-035 start with numFrames=0, then samples -> state stays IDLE, busy=0, no outValid.
REQ-036 IN_WIDTH=8, samples -128,127 in one frame -> dataOut holds -128 and 127 exactly, no truncation or sign error.
REQ-037 rst pulsed mid-way through frame 2 of 3 -> outputs zero immediately without a clock edge; no further outValid until a new start; the new capture's first frame starts at slot 0.
REQ-038 In DONE, apply start and 20 valid samples -> done and closed stay 1, no outValid, dataOut unchanged.
